// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port framebuffer memory between the display
// line prefetcher and the CPU.
//
// During horizontal blanking of line v-1 the next display line v is fetched,
// word by word, into the off-screen half of a ping-pong line buffer. The display
// side has strict priority. The CPU is served only when no display fetch is
// pending, which in practice means the rest of each line plus all of vblank.
// A line fetch that is not finished by the end of its line raises a sticky
// underrun flag and is abandoned.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   cnt_h, cnt_v                    video counters shared with the sync generator
//   cpu_req/we/addr/wdata           CPU request, held stable until cpu_ack
//   cpu_ack, cpu_rdata              1-cycle completion pulse, read data (held)
//   mem_req/we/addr/wdata           memory request, held stable until mem_ack
//   mem_ack, mem_rdata              memory completion and read data
//   lb_we/bank/addr/wdata           line-buffer write port
//   lb_sel                          line-buffer half currently displayed
//   underrun, underrun_clr          sticky deadline-miss flag and its clear

module vram_arbiter #(
    parameter int unsigned H_ACTIVE   = 848,
    parameter int unsigned H_TOTAL    = 1088,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_TOTAL    = 517,
    parameter int unsigned LINE_WORDS = 106,
    parameter int unsigned FB_BASE    = 0,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DW         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       cnt_h,
    input  logic [9:0]        cnt_v,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    output logic              cpu_ack,
    output logic [DW-1:0]     cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_ack,
    input  logic [DW-1:0]     mem_rdata,
    output logic              lb_we,
    output logic              lb_bank,
    output logic [6:0]        lb_addr,
    output logic [DW-1:0]     lb_wdata,
    output logic              lb_sel,
    output logic              underrun,
    input  logic              underrun_clr
);

    // Counter compare values at the counters' own widths.
    localparam logic [10:0]       HFetch    = 11'(H_ACTIVE);
    localparam logic [10:0]       HLast     = 11'(H_TOTAL - 1);
    localparam logic [9:0]        VLastAct  = 10'(V_ACTIVE - 1);
    localparam logic [9:0]        VLast     = 10'(V_TOTAL - 1);
    localparam logic [6:0]        LineWrds  = 7'(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LineStep  = ADDR_W'(LINE_WORDS);
    localparam logic [ADDR_W-1:0] FbBase    = ADDR_W'(FB_BASE);

    typedef enum logic [1:0] {StIdle, StDisp, StCpu} state_e;

    state_e            state_q, state_d;
    logic              pending_q, pending_d;
    logic [6:0]        word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] line_ptr_q, line_ptr_d;
    logic [ADDR_W-1:0] row_ptr_q, row_ptr_d;
    logic [9:0]        cnt_v_q;
    logic              fetch_line_q, fetch_line_d;
    logic              lb_bank_q, lb_bank_d;
    logic              lb_sel_q, lb_sel_d;
    logic              underrun_q, underrun_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
    logic              lb_we_q, lb_we_d;
    logic [6:0]        lb_addr_q, lb_addr_d;
    logic [DW-1:0]     lb_wdata_q, lb_wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [DW-1:0]     cpu_rdata_q, cpu_rdata_d;

    logic fetch_start;
    logic deadline;
    logic disp_want;

    // Fetch for line v+1 starts at the first blanking pixel of line v. The last
    // active line and the vblank lines start nothing, except the final vblank
    // line, which prefetches line 0 of the next frame.
    assign fetch_start = (cnt_h == HFetch) && ((cnt_v < VLastAct) || (cnt_v == VLast));
    assign deadline    = (cnt_h == HLast) && fetch_line_q;

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        word_cnt_d   = word_cnt_q;
        line_ptr_d   = line_ptr_q;
        row_ptr_d    = row_ptr_q;
        fetch_line_d = fetch_line_q;
        lb_bank_d    = lb_bank_q;
        lb_sel_d     = lb_sel_q;
        underrun_d   = underrun_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        lb_we_d      = 1'b0;
        lb_addr_d    = lb_addr_q;
        lb_wdata_d   = lb_wdata_q;
        cpu_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        disp_want    = 1'b0;

        // row_ptr follows the address of line cnt_v by stepping one line at a
        // time whenever cnt_v moves, so no multiplier is needed.
        if (cnt_v != cnt_v_q) begin
            row_ptr_d = (cnt_v == '0) ? FbBase : row_ptr_q + LineStep;
        end

        if (fetch_start) begin
            pending_d    = 1'b1;
            word_cnt_d   = '0;
            line_ptr_d   = (cnt_v == VLast) ? FbBase : row_ptr_q + LineStep;
            lb_bank_d    = ~lb_sel_q;
            fetch_line_d = 1'b1;
        end

        // End of line: show the freshly fetched half; an unfinished fetch is
        // abandoned, though an access already in flight is allowed to land.
        if (deadline) begin
            lb_sel_d     = lb_bank_q;
            fetch_line_d = 1'b0;
            if (word_cnt_q < LineWrds) begin
                underrun_d = 1'b1;
                pending_d  = 1'b0;
            end
        end

        if (!(deadline && (word_cnt_q < LineWrds)) && underrun_clr) begin
            underrun_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                // Next-state values are used so a fetch starting this cycle
                // beats a simultaneous CPU request, and a deadline this cycle
                // blocks any new display word.
                disp_want = pending_d && (word_cnt_d < LineWrds);
                if (disp_want) begin
                    state_d     = StDisp;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = line_ptr_d + {{(ADDR_W - 7){1'b0}}, word_cnt_d};
                    mem_wdata_d = '0;
                end else if (cpu_req && !cpu_ack_q) begin
                    // cpu_req is still high in the ack cycle; don't reissue it.
                    state_d     = StCpu;
                    mem_we_d    = cpu_we;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                end
            end
            StDisp: begin
                if (mem_ack) begin
                    state_d    = StIdle;
                    lb_we_d    = 1'b1;
                    lb_addr_d  = word_cnt_q;
                    lb_wdata_d = mem_rdata;
                    if (!fetch_start) begin
                        word_cnt_d = word_cnt_q + 7'd1;
                        if (word_cnt_q + 7'd1 >= LineWrds) begin
                            pending_d = 1'b0;
                        end
                    end
                end
            end
            StCpu: begin
                if (mem_ack) begin
                    state_d   = StIdle;
                    cpu_ack_d = 1'b1;
                    if (!mem_we_q) begin
                        cpu_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pending_q    <= 1'b0;
            word_cnt_q   <= '0;
            line_ptr_q   <= FbBase;
            row_ptr_q    <= FbBase;
            cnt_v_q      <= '0;
            fetch_line_q <= 1'b0;
            lb_bank_q    <= 1'b0;
            lb_sel_q     <= 1'b0;
            underrun_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            lb_we_q      <= 1'b0;
            lb_addr_q    <= '0;
            lb_wdata_q   <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            word_cnt_q   <= word_cnt_d;
            line_ptr_q   <= line_ptr_d;
            row_ptr_q    <= row_ptr_d;
            cnt_v_q      <= cnt_v;
            fetch_line_q <= fetch_line_d;
            lb_bank_q    <= lb_bank_d;
            lb_sel_q     <= lb_sel_d;
            underrun_q   <= underrun_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            lb_we_q      <= lb_we_d;
            lb_addr_q    <= lb_addr_d;
            lb_wdata_q   <= lb_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

    // mem_req comes straight from the state register, so reset drops it at once.
    assign mem_req   = (state_q != StIdle);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign lb_we     = lb_we_q;
    assign lb_bank   = lb_bank_q;
    assign lb_addr   = lb_addr_q;
    assign lb_wdata  = lb_wdata_q;
    assign lb_sel    = lb_sel_q;
    assign underrun  = underrun_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter. A small memory model answers each
// request after ack_delay cycles; read data encodes the address unless a fixed
// word is selected.

module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] cnt_h;
    logic [9:0]  cnt_v;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        lb_we, lb_bank, lb_sel, underrun, underrun_clr;
    logic [6:0]  lb_addr;
    logic [31:0] lb_wdata;

    int compared   = 0;
    int mismatched = 0;

    int          ack_delay   = 0;
    int          wait_cnt    = 0;
    logic        use_fixed   = 1'b0;
    logic [31:0] fixed_rdata = 32'h0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    assign mem_ack   = mem_req && (wait_cnt == ack_delay);
    assign mem_rdata = use_fixed ? fixed_rdata : {16'hA5A5, mem_addr};

    vram_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cnt_h        (cnt_h),
        .cnt_v        (cnt_v),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ack      (cpu_ack),
        .cpu_rdata    (cpu_rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .lb_we        (lb_we),
        .lb_bank      (lb_bank),
        .lb_addr      (lb_addr),
        .lb_wdata     (lb_wdata),
        .lb_sel       (lb_sel),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance cnt_v one line per clock (cnt_h parked at 0) up to the target.
    task automatic step_v(input int target);
        cnt_h = 11'd0;
        while (cnt_v != 10'(target)) begin
            cnt_v = (cnt_v == 10'd516) ? 10'd0 : cnt_v + 10'd1;
            tick();
        end
        tick();
    endtask

    int pulses, reqs, acks, cpu_reqs, saw_req, ack_at, seen;

    initial begin
        rst_n = 1'b0; cnt_h = '0; cnt_v = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        underrun_clr = 1'b0;
        #12;
        chk("rst_mem_req",  32'(mem_req),  32'd0);
        chk("rst_lb_sel",   32'(lb_sel),   32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_cpu_ack",  32'(cpu_ack),  32'd0);
        chk("rst_lb_we",    32'(lb_we),    32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Test 1: reset in the middle of a display transfer
        ack_delay = 5;
        cnt_h = 11'd848;
        tick();
        cnt_h = 11'd849;
        @(negedge clk);
        chk("t1_mem_req_busy", 32'(mem_req), 32'd1);
        chk("t1_mem_addr",     32'(mem_addr), 32'd106);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_mem_req",  32'(mem_req),  32'd0);
        chk("t1_lb_we",    32'(lb_we),    32'd0);
        chk("t1_cpu_ack",  32'(cpu_ack),  32'd0);
        chk("t1_underrun", 32'(underrun), 32'd0);
        chk("t1_lb_sel",   32'(lb_sel),   32'd0);
        @(posedge clk); #1;
        cnt_h = 11'd0;
        rst_n = 1'b1;
        ack_delay = 0;
        tick();

        // Test 2: full line fetch for line 5 with zero-wait memory
        step_v(4);
        pulses = 0; reqs = 0;
        for (int h = 848; h < 1088; h++) begin
            cnt_h = 11'(h);
            @(negedge clk);
            if (mem_req) begin
                chk("t2_mem_addr", 32'(mem_addr), 32'(530 + pulses));
                chk("t2_mem_we",   32'(mem_we),   32'd0);
                reqs++;
            end
            if (lb_we) begin
                chk("t2_lb_addr",  32'(lb_addr), 32'(pulses));
                chk("t2_lb_wdata", lb_wdata, {16'hA5A5, 16'(530 + pulses)});
                chk("t2_lb_bank",  32'(lb_bank), 32'd1);
                pulses++;
            end
            @(posedge clk); #1;
        end
        cnt_h = 11'd0;
        chk("t2_pulses",   32'(pulses),   32'd106);
        chk("t2_reqs",     32'(reqs),     32'd106);
        chk("t2_lb_sel",   32'(lb_sel),   32'd1);
        chk("t2_underrun", 32'(underrun), 32'd0);

        // Test 4: CPU write waits behind the whole display fetch
        step_v(10);
        pulses = 0; acks = 0; cpu_reqs = 0;
        for (int h = 848; h < 1088; h++) begin
            cnt_h = 11'(h);
            if (h == 850) begin
                cpu_req = 1'b1; cpu_we = 1'b1;
                cpu_addr = 16'h1234; cpu_wdata = 32'hDEADBEEF;
            end
            @(negedge clk);
            if (lb_we) pulses++;
            if (mem_req && mem_we) begin
                cpu_reqs++;
                chk("t4_order",     32'(pulses),  32'd106);
                chk("t4_mem_addr",  32'(mem_addr), 32'h1234);
                chk("t4_mem_wdata", mem_wdata,     32'hDEADBEEF);
            end
            if (cpu_ack) acks++;
            @(posedge clk); #1;
            if (acks > 0) cpu_req = 1'b0;
        end
        cnt_h = 11'd0;
        chk("t4_pulses",   32'(pulses),   32'd106);
        chk("t4_cpu_reqs", 32'(cpu_reqs), 32'd1);
        chk("t4_acks",     32'(acks),     32'd1);
        chk("t4_lb_sel",   32'(lb_sel),   32'd0);
        chk("t4_underrun", 32'(underrun), 32'd0);

        // Test 5: one wait state per word -> 3 cycles/word, deadline missed
        step_v(11);
        ack_delay = 1;
        pulses = 0;
        for (int h = 848; h < 1088; h++) begin
            cnt_h = 11'(h);
            @(negedge clk);
            if (lb_we) pulses++;
            @(posedge clk); #1;
        end
        cnt_h = 11'd0;
        chk("t5_pulses_in_line", 32'(pulses),   32'd79);
        chk("t5_underrun",       32'(underrun), 32'd1);
        chk("t5_lb_sel",         32'(lb_sel),   32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (lb_we) pulses++;
            @(posedge clk); #1;
        end
        chk("t5_pulses_total", 32'(pulses),   32'd80);
        chk("t5_no_new_req",   32'(mem_req),  32'd0);
        chk("t5_sticky",       32'(underrun), 32'd1);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        chk("t5_clr", 32'(underrun), 32'd0);

        // Test 3a: last active line starts no fetch
        ack_delay = 0;
        step_v(479);
        saw_req = 0;
        for (int h = 848; h < 1088; h++) begin
            cnt_h = 11'(h);
            @(negedge clk);
            if (mem_req) saw_req++;
            @(posedge clk); #1;
        end
        chk("t3_no_req_479", 32'(saw_req), 32'd0);

        // Test 6: CPU read in vblank with two wait states
        step_v(490);
        ack_delay = 2;
        use_fixed = 1'b1; fixed_rdata = 32'hCAFEF00D;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042;
        ack_at = -1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (mem_req) chk("t6_mem_we", 32'(mem_we), 32'd0);
            if (cpu_ack) begin
                ack_at = n;
                break;
            end
            @(posedge clk); #1;
        end
        chk("t6_ack_latency", 32'(ack_at),  32'd4);
        chk("t6_cpu_rdata",   cpu_rdata,    32'hCAFEF00D);
        @(posedge clk); #1;
        cpu_req = 1'b0; use_fixed = 1'b0; ack_delay = 0;
        tick(); tick();
        chk("t6_rdata_held", cpu_rdata,    32'hCAFEF00D);
        chk("t6_single_ack", 32'(cpu_ack), 32'd0);

        // Test 3b: vblank line 515 quiet, line 516 prefetches frame line 0
        step_v(515);
        saw_req = 0;
        for (int h = 848; h < 1088; h++) begin
            cnt_h = 11'(h);
            @(negedge clk);
            if (mem_req) saw_req++;
            @(posedge clk); #1;
        end
        chk("t3_no_req_515", 32'(saw_req), 32'd0);
        step_v(516);
        seen = 0; pulses = 0;
        for (int h = 848; h < 1088; h++) begin
            cnt_h = 11'(h);
            @(negedge clk);
            if (mem_req && seen == 0) begin
                chk("t3_first_addr", 32'(mem_addr), 32'd0);
                chk("t3_lb_bank",    32'(lb_bank),  32'd0);
                seen = 1;
            end
            if (lb_we) pulses++;
            @(posedge clk); #1;
        end
        cnt_h = 11'd0;
        chk("t3_seen",   32'(seen),   32'd1);
        chk("t3_pulses", 32'(pulses), 32'd106);
        chk("t3_lb_sel", 32'(lb_sel), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
